// File: rtl/axi_intr_ctrl_n.sv
// AXI4-Lite interrupt controller: N_SRC synchronised sources with per-source
// edge/level mode and polarity, aggregated onto a single irq line.
module axi_intr_ctrl_n #(
    parameter int unsigned N_SRC            = 4,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter logic        IRQ_ACTIVE_STATE = 1'b1,
    parameter int unsigned IRQ_SENSITIVITY  = 0,
    parameter int unsigned ADDR_W           = 5
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [N_SRC-1:0]  intr_src,
    output logic              irq,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    localparam int unsigned OFS_W = ADDR_W - 2;

    localparam logic [OFS_W-1:0] OFS_GIE  = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_IER  = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_RAW  = OFS_W'(2);
    localparam logic [OFS_W-1:0] OFS_ACK  = OFS_W'(3);
    localparam logic [OFS_W-1:0] OFS_PEND = OFS_W'(4);
    localparam logic [OFS_W-1:0] OFS_MODE = OFS_W'(5);
    localparam logic [OFS_W-1:0] OFS_POL  = OFS_W'(6);

    // Register state
    logic             gie;
    logic [N_SRC-1:0] ier;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pol;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] s_d;
    logic [N_SRC-1:0] hist_vld;
    logic             irq_lvl_q;
    logic             irq_q;

    // AXI handshake state
    logic        awready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // Combinational next-state
    logic             gie_nx;
    logic [N_SRC-1:0] ier_nx;
    logic [N_SRC-1:0] mode_nx;
    logic [N_SRC-1:0] pol_nx;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] src_sync;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] edge_evt;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_nx;
    logic [N_SRC-1:0] hist_clr;
    logic             irq_lvl_nx;
    logic             irq_fire;
    logic [31:0]      strb_mask;
    logic [31:0]      wr_bits;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic [OFS_W-1:0] wr_ofs;
    logic [OFS_W-1:0] rd_ofs;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Input synchroniser chain (bypassed when SYNC_STAGES is 0)
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_sync = intr_src;
        end else begin : g_sync
            logic [N_SRC-1:0] sync_ff [SYNC_STAGES];

            // Shift raw sources through the synchroniser flops
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        sync_ff[k] <= '0;
                    end
                end else begin
                    sync_ff[0] <= intr_src;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                        sync_ff[k] <= sync_ff[k-1];
                    end
                end
            end

            assign src_sync = sync_ff[SYNC_STAGES-1];
        end
    endgenerate

    assign wr_en     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en     = arready_q & S_AXI_ARVALID;
    assign wr_ofs    = S_AXI_AWADDR[ADDR_W-1:2];
    assign rd_ofs    = S_AXI_ARADDR[ADDR_W-1:2];
    assign strb_mask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                        {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign wr_bits   = S_AXI_WDATA & strb_mask;

    // Register write decode with per-byte strobes
    always_comb begin
        gie_nx  = gie;
        ier_nx  = ier;
        mode_nx = mode;
        pol_nx  = pol;
        ack_clr = '0;
        if (wr_en) begin
            case (wr_ofs)
                OFS_GIE:  gie_nx  = S_AXI_WSTRB[0] ? S_AXI_WDATA[0] : gie;
                OFS_IER:  ier_nx  = N_SRC'((32'(ier)  & ~strb_mask) | wr_bits);
                OFS_ACK:  ack_clr = N_SRC'(wr_bits);
                OFS_MODE: mode_nx = N_SRC'((32'(mode) & ~strb_mask) | wr_bits);
                OFS_POL:  pol_nx  = N_SRC'((32'(pol)  & ~strb_mask) | wr_bits);
                default:  ;
            endcase
        end
    end

    // Source conditioning, edge detection and pending update (set beats ack)
    always_comb begin
        s          = src_sync ^ pol;
        edge_evt   = s & ~s_d & hist_vld;
        pend_set   = ier & ((mode & edge_evt) | (~mode & s));
        pend_nx    = (pend & ~ack_clr) | pend_set;
        hist_clr   = (mode_nx ^ mode) | (pol_nx ^ pol);
        irq_lvl_nx = gie & (|(pend & ier));
        irq_fire   = (IRQ_SENSITIVITY == 0) ? irq_lvl_nx : (irq_lvl_nx & ~irq_lvl_q);
    end

    // Read data mux; unused bits and unmapped offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (rd_ofs)
            OFS_GIE:  rd_mux = 32'(gie);
            OFS_IER:  rd_mux = 32'(ier);
            OFS_RAW:  rd_mux = 32'(s);
            OFS_PEND: rd_mux = 32'(pend);
            OFS_MODE: rd_mux = 32'(mode);
            OFS_POL:  rd_mux = 32'(pol);
            default:  rd_mux = '0;
        endcase
    end

    // Control/status registers, edge history and irq generation
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gie       <= 1'b0;
            ier       <= '0;
            mode      <= '0;
            pol       <= '0;
            pend      <= '0;
            s_d       <= '0;
            hist_vld  <= '0;
            irq_lvl_q <= 1'b0;
            irq_q     <= ~IRQ_ACTIVE_STATE;
        end else begin
            gie       <= gie_nx;
            ier       <= ier_nx;
            mode      <= mode_nx;
            pol       <= pol_nx;
            pend      <= pend_nx;
            s_d       <= s & ~hist_clr;
            hist_vld  <= ~hist_clr;
            irq_lvl_q <= irq_lvl_nx;
            irq_q     <= irq_fire ? IRQ_ACTIVE_STATE : ~IRQ_ACTIVE_STATE;
        end
    end

    // Write channel: accept AW+W together, hold response until BREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle latency, data held until RREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign irq           = irq_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_intr_ctrl_n.sv
// Bench for axi_intr_ctrl_n: directed register/irq scenarios plus randomized
// configurations checked against a rule-level pending model.
module tb_axi_intr_ctrl_n;

    localparam logic [4:0] A_GIE  = 5'h00;
    localparam logic [4:0] A_IER  = 5'h04;
    localparam logic [4:0] A_RAW  = 5'h08;
    localparam logic [4:0] A_ACK  = 5'h0C;
    localparam logic [4:0] A_PEND = 5'h10;
    localparam logic [4:0] A_MODE = 5'h14;
    localparam logic [4:0] A_POL  = 5'h18;
    localparam logic [4:0] A_UNM  = 5'h1C;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  intr_src;
    logic        irq0, irq1;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        p_awready, p_wready, p_bvalid, p_arready, p_rvalid;
    logic [1:0]  p_bresp, p_rresp;
    logic [31:0] p_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0]  last_bresp;
    logic [31:0] rd;

    always #5 ACLK = ~ACLK;

    axi_intr_ctrl_n #(.N_SRC(4), .SYNC_STAGES(2), .IRQ_ACTIVE_STATE(1'b1),
                      .IRQ_SENSITIVITY(0), .ADDR_W(5)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .intr_src(intr_src), .irq(irq0),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready));

    axi_intr_ctrl_n #(.N_SRC(4), .SYNC_STAGES(2), .IRQ_ACTIVE_STATE(1'b1),
                      .IRQ_SENSITIVITY(1), .ADDR_W(5)) dut_pulse (
        .ACLK(ACLK), .ARESET(ARESET), .intr_src(intr_src), .irq(irq1),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(p_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(p_wready), .S_AXI_BRESP(p_bresp), .S_AXI_BVALID(p_bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(p_arready), .S_AXI_RDATA(p_rdata), .S_AXI_RRESP(p_rresp),
        .S_AXI_RVALID(p_rvalid), .S_AXI_RREADY(rready));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
        bit ok;
        ok = 1'b0;
        awaddr = a; wdata = d; wstrb = st;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_handshake", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (bvalid) begin ok = 1'b1; last_bresp = bresp; break; end
        end
        @(posedge ACLK); #1;
        check("b_response", 32'(ok), 32'd1);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        bit ok;
        ok = 1'b0;
        d = 32'hDEAD_BEEF;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (rvalid) begin ok = 1'b1; d = rdata; break; end
        end
        @(posedge ACLK); #1;
        check("r_response", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [3:0] pol, mode, ier, b0, b1, s0, s1, ackm, exp_p;
        logic [3:0] ack_st;
        int cnt;

        ARESET = 1'b1; intr_src = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        last_bresp = 2'b11;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_hs", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {30'd0, irq0, irq1}, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        tick(2);

        // Every register reads zero after reset
        for (int i = 0; i <= 6; i++) begin
            axi_read(5'(i * 4), rd);
            check($sformatf("rst_reg_%0h", i * 4), rd, 32'd0);
        end

        // Unmapped offset: write ignored, OKAY, reads zero
        axi_write(A_UNM, 32'hFFFF_FFFF, 4'hF);
        check("unm_bresp", 32'(last_bresp), 32'd0);
        axi_read(A_UNM, rd);
        check("unm_read", rd, 32'd0);

        // Edge mode on src0 with 1-cycle pulse; irq timing
        axi_write(A_GIE, 32'h1, 4'hF);
        axi_write(A_IER, 32'h1, 4'hF);
        axi_write(A_MODE, 32'h1, 4'hF);
        intr_src[0] = 1'b1;
        tick(1);
        intr_src[0] = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("edge_irq_early", 32'(irq0), 32'd0);
        @(negedge ACLK);
        check("edge_irq", 32'(irq0), 32'd1);
        check("edge_pulse_on", 32'(irq1), 32'd1);
        @(negedge ACLK);
        check("edge_pulse_off", 32'(irq1), 32'd0);
        #6;
        axi_read(A_PEND, rd);
        check("edge_pend", rd, 32'h1);
        axi_write(A_ACK, 32'h1, 4'hF);
        axi_read(A_PEND, rd);
        check("edge_ack_pend", rd, 32'h0);
        check("edge_ack_irq", 32'(irq0), 32'd0);

        // Level mode on src2: active source survives ACK
        axi_write(A_MODE, 32'h0, 4'hF);
        axi_write(A_IER, 32'h4, 4'hF);
        intr_src[2] = 1'b1;
        tick(4);
        axi_read(A_PEND, rd);
        check("lvl_pend", rd, 32'h4);
        axi_write(A_ACK, 32'h4, 4'hF);
        axi_read(A_PEND, rd);
        check("lvl_reassert", rd, 32'h4);
        intr_src[2] = 1'b0;
        tick(4);
        axi_read(A_PEND, rd);
        check("lvl_latched", rd, 32'h4);
        axi_write(A_ACK, 32'h4, 4'hF);
        axi_read(A_PEND, rd);
        check("lvl_cleared", rd, 32'h0);

        // Active-low polarity and GIE masking
        axi_write(A_POL, 32'h2, 4'hF);
        axi_write(A_IER, 32'h2, 4'hF);
        tick(4);
        axi_read(A_RAW, rd);
        check("pol_raw", rd, 32'h2);
        axi_read(A_PEND, rd);
        check("pol_pend", rd, 32'h2);
        check("pol_irq", 32'(irq0), 32'd1);
        axi_write(A_GIE, 32'h0, 4'hF);
        tick(2);
        check("gie_off_irq", 32'(irq0), 32'd0);
        axi_read(A_PEND, rd);
        check("gie_off_pend", rd, 32'h2);
        axi_write(A_POL, 32'h0, 4'hF);
        axi_write(A_ACK, 32'hF, 4'hF);
        axi_write(A_GIE, 32'h1, 4'hF);

        // Edge event landing on the same edge as ACK: set wins
        axi_write(A_IER, 32'h1, 4'hF);
        axi_write(A_MODE, 32'h1, 4'hF);
        axi_write(A_ACK, 32'hF, 4'hF);
        intr_src[0] = 1'b1;
        tick(1);
        axi_write(A_ACK, 32'h1, 4'hF);
        intr_src[0] = 1'b0;
        axi_read(A_PEND, rd);
        check("set_wins", rd, 32'h1);

        // Pulse build: two edge sources 3 cycles apart give one pulse
        axi_write(A_IER, 32'h3, 4'hF);
        axi_write(A_MODE, 32'h3, 4'hF);
        axi_write(A_ACK, 32'hF, 4'hF);
        tick(4);
        cnt = 0;
        intr_src[0] = 1'b1; tick(1); intr_src[0] = 1'b0;
        tick(2);
        intr_src[1] = 1'b1; tick(1); intr_src[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (irq1) cnt++;
        end
        #6;
        check("pulse_count", 32'(cnt), 32'd1);
        check("pulse_lvl_irq", 32'(irq0), 32'd1);
        axi_read(A_PEND, rd);
        check("pulse_pend", rd, 32'h3);

        // BREADY held low: BVALID holds, no second write accepted
        axi_write(A_IER, 32'h0, 4'hF);
        awaddr = A_IER; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (awready) break;
            cnt++;
        end
        check("bp_accept", 32'(cnt < 50), 32'd1);
        @(posedge ACLK); #1;
        wdata = 32'h2;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_awready", 32'(awready), 32'd0);
        end
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick(2);
        axi_read(A_IER, rd);
        check("bp_ier", rd, 32'h1);

        // Byte strobes on a RW register
        axi_write(A_IER, 32'hF, 4'hE);
        axi_read(A_IER, rd);
        check("strb_off", rd, 32'h1);
        axi_write(A_IER, 32'hF, 4'h1);
        axi_read(A_IER, rd);
        check("strb_on", rd, 32'hF);

        // Reset mid-write aborts with no response
        awaddr = A_IER; wdata = 32'h0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (awready) break;
        end
        ARESET = 1'b1;
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge ACLK); #1 ARESET = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            if (bvalid) cnt++;
        end
        #6;
        check("abort_no_b", 32'(cnt), 32'd0);
        axi_read(A_IER, rd);
        check("abort_ier", rd, 32'h0);

        // Randomized configurations against the rule-level model
        axi_write(A_GIE, 32'h1, 4'hF);
        for (int it = 0; it < 8; it++) begin
            pol  = 4'($urandom); mode = 4'($urandom); ier = 4'($urandom);
            b0   = 4'($urandom); b1   = 4'($urandom);
            ackm = 4'($urandom); ack_st = 4'($urandom);
            s0 = b0 ^ pol;
            s1 = b1 ^ pol;

            intr_src = b0;
            axi_write(A_POL, 32'(pol), 4'hF);
            axi_write(A_MODE, 32'(mode), 4'hF);
            axi_write(A_IER, 32'(ier), 4'hF);
            tick(4);
            axi_write(A_ACK, 32'hF, 4'hF);
            tick(3);
            exp_p = ier & ~mode & s0;
            axi_read(A_PEND, rd);
            check($sformatf("rnd%0d_pend0", it), rd, 32'(exp_p));
            check($sformatf("rnd%0d_irq0", it), 32'(irq0), 32'(|exp_p));

            intr_src = b1;
            tick(5);
            exp_p = exp_p | (ier & ((~mode & s1) | (mode & s1 & ~s0)));
            axi_read(A_PEND, rd);
            check($sformatf("rnd%0d_pend1", it), rd, 32'(exp_p));
            axi_read(A_RAW, rd);
            check($sformatf("rnd%0d_raw", it), rd, 32'(s1));
            check($sformatf("rnd%0d_irq1", it), 32'(irq0), 32'(|exp_p));

            axi_write(A_ACK, 32'(ackm), ack_st);
            if (ack_st[0]) exp_p = exp_p & ~ackm;
            exp_p = exp_p | (ier & ~mode & s1);
            axi_read(A_PEND, rd);
            check($sformatf("rnd%0d_pend2", it), rd, 32'(exp_p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
